// File: rtl/uart_sink_pkg.sv
// uart_sink_pkg: receiver states and frame constants shared by the UART sink
package uart_sink_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int MIN_DIV = 4;
endpackage

// File: rtl/uart_sink_fifo.sv
// uart_sink_fifo: byte FIFO with head-of-queue output and exact occupancy count
module uart_sink_fifo #(
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int AW = $clog2(Depth);
  logic [7:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(Depth);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_sink.sv
// uart_tx_sink: 8N1 serial receiver feeding a byte FIFO with frame-error and overflow flags
module uart_tx_sink
  import uart_sink_pkg::*;
#(
  parameter int FifoDepth = 8,
  parameter int DivW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DivW-1:0]            div_i,
  input  logic                       rx_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       frame_err_o,
  output logic                       overflow_o,
  input  logic                       clr_i,
  output logic                       busy_o,
  output logic [$clog2(FifoDepth):0] count_o
);
  rx_state_t state;
  logic rx_meta, rxs, rxs_q;
  logic [DivW-1:0] div_q, cnt, div_eff;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic tick, push, pop, full, empty, drop;
  assign div_eff = div_i < DivW'(MIN_DIV) ? DivW'(MIN_DIV) : div_i;
  assign tick = cnt == DivW'(1);
  assign push = state == STOP && tick && rxs;
  assign pop = valid_o && ready_i;
  assign drop = push && full && !pop;
  assign valid_o = !empty;
  assign busy_o = state != IDLE;
  uart_sink_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .din(shift),
    .pop(pop),
    .dout(data_o),
    .full(full),
    .empty(empty),
    .count(count_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      rxs_q <= 1'b1;
      state <= IDLE;
      div_q <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      frame_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rxs <= rx_meta;
      rxs_q <= rxs;
      frame_err_o <= 1'b0;
      overflow_o <= drop || (overflow_o && !clr_i);
      case (state)
        IDLE: begin
          if (!rxs && rxs_q) begin
            state <= START;
            div_q <= div_eff;
            cnt <= div_eff >> 1;
          end
        end
        START: begin
          cnt <= tick ? div_q : cnt - DivW'(1);
          bit_cnt <= '0;
          if (tick) state <= rxs ? IDLE : DATA;
        end
        DATA: begin
          cnt <= tick ? div_q : cnt - DivW'(1);
          if (tick) begin
            shift <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          cnt <= tick ? cnt : cnt - DivW'(1);
          if (tick) begin
            state <= rxs ? IDLE : WAIT_HIGH;
            frame_err_o <= !rxs;
          end
        end
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_sink.md
UART_TX_SINK -- requirements
Module: uart_tx_sink

Interface
REQ-001 SHALL have parameter FifoDepth, default 8, meaning received-byte buffer entries (power of two, >=2).
REQ-002 SHALL have parameter DivW, default 16, meaning width of the bit-period divisor.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port div_i  input  DivW  meaning clock cycles per UART bit.
REQ-006 SHALL have port rx_i  input  1  meaning serial line from the DUT uart_tx_o, asynchronous, idle high.
REQ-007 SHALL have port data_o  output  8  meaning the head-of-buffer byte.
REQ-008 SHALL have port valid_o  output  1  meaning data_o holds a byte.
REQ-009 SHALL have port ready_i  input  1  meaning the consumer accepts data_o.
REQ-010 SHALL have port frame_err_o  output  1  meaning one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overflow_o  output  1  meaning sticky flag that a byte was dropped because the buffer was full.
REQ-012 SHALL have port clr_i  input  1  meaning clears overflow_o.
REQ-013 SHALL have port busy_o  output  1  meaning a frame is being received (state not IDLE).
REQ-014 SHALL have port count_o  output  $clog2(FifoDepth)+1  meaning buffer occupancy.

Function
REQ-015 rx_i SHALL pass through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized value rxs.
REQ-016 Format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-017 Effective divisor SHALL be max(div_i,4), latched on start detection; changes to div_i mid-frame SHALL have no effect.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-019 IDLE -> START when rxs is 0 while the previous rxs was 1; bit counter loaded with div/2 (floor).
REQ-020 START: on counter expiry sample rxs; 1 -> IDLE (glitch, no output); 0 -> DATA, counter reloaded with div.
REQ-021 DATA: on each counter expiry shift rxs into bit 7 of the shift register (right shift); after the 8th sample -> STOP, counter reloaded with div.
REQ-022 STOP: on expiry, rxs=1 -> push byte, go IDLE; rxs=0 -> pulse frame_err_o for exactly one cycle, discard byte, go WAIT_HIGH.
REQ-023 WAIT_HIGH -> IDLE once rxs is 1; no start detection while in WAIT_HIGH.
REQ-024 A pushed byte SHALL appear on data_o/valid_o in the cycle after the stop-sample cycle when the buffer was empty.
REQ-025 Pop SHALL occur when valid_o and ready_i are both 1; valid_o/data_o SHALL not change while valid_o=1 and ready_i=0.
REQ-026 Push while full SHALL be accepted if a pop occurs in the same cycle; otherwise the byte is dropped and overflow_o set.
REQ-027 Simultaneous push and pop on an empty buffer SHALL not bypass: the byte is stored, valid_o rises next cycle.
REQ-028 count_o SHALL be exact every cycle; FIFO order preserved, pointers wrap modulo FifoDepth.
REQ-029 clr_i SHALL clear overflow_o next cycle; a drop in the same cycle as clr_i SHALL leave overflow_o set (set wins).

Reset
REQ-030 rst_i SHALL, at any time including mid-frame, force state IDLE, synchronizer flops to 1, buffer empty, valid_o=0, count_o=0, frame_err_o=0, overflow_o=0, busy_o=0, data_o=0.
REQ-031 A frame in progress at reset SHALL be abandoned; decoding restarts on the next falling edge after reset release.

Structure
REQ-032 Package uart_sink_pkg SHALL hold the FSM state enum, the data-bits constant (8) and the minimum-divisor constant (4).
REQ-033 Buffer SHALL be one sub-module uart_sink_fifo (parameter Depth, 8-bit data, push/pop/full/empty/count).
REQ-034 Total RTL (top plus FIFO) SHALL be 120-400 lines.

Verification
REQ-035 div=16, send 0xA5 -> valid_o=1, data_o=0xA5, frame_err_o never pulses, count_o=1.
REQ-036 div=16, rx_i low for 5 cycles then high -> no byte, state returns to IDLE, busy_o falls.
REQ-037 div=16, send 0x3C with stop bit 0 -> one frame_err_o pulse, count_o stays 0, no new frame until rx_i high.
REQ-038 ready_i=0, send bytes 0x00..0x08 -> count_o=8, overflow_o=1, drain yields 0x00..0x07 in order; clr_i clears overflow_o.
REQ-039 rst_i asserted during DATA of byte 0x55, then send 0x81 -> only 0x81 received.
REQ-040 div=3 then div=4, back-to-back 0x12,0x34 with ready_i=1 -> both received correctly (div=3 treated as 4).
